// File: rtl/demux3_stream_pkg.sv
// Shared constants for the 3-way stream demultiplexer: word width and select encodings.
// The RV32I-wide defines are guarded so another defs file may provide them first.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef SEL_CH0
`define SEL_CH0 2'b00
`endif
`ifndef SEL_CH1
`define SEL_CH1 2'b01
`endif
`ifndef SEL_CH2
`define SEL_CH2 2'b10
`endif
`ifndef SEL_BAD
`define SEL_BAD 2'b11
`endif

package demux3_stream_pkg;

  localparam int unsigned WORD_W = `WORD_WIDTH;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned N_CH   = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_CH0 = `SEL_CH0,
    SEL_CH1 = `SEL_CH1,
    SEL_CH2 = `SEL_CH2,
    SEL_BAD = `SEL_BAD
  } sel_e;

endpackage

// File: rtl/demux3_slot.sv
// One-entry register slice: holds a beat until the sink takes it, accepts a new beat
// whenever it is empty or draining in the same cycle.
module demux3_slot #(
  parameter int unsigned NB = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [NB-1:0] ld_data,
  output logic          valid,
  input  logic          ready,
  output logic [NB-1:0] data,
  output logic          load_ok
);

  logic          valid_q, valid_d;
  logic [NB-1:0] data_q, data_d;

  // A load wins over a drain so back-to-back beats flow without a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ld) begin
      valid_d = 1'b1;
      data_d  = ld_data;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign load_ok = !valid_q || ready;

endmodule

// File: rtl/demux3_stream.sv
// 3-way stream demultiplexer: steers each input beat to one of three registered output slots
// by a per-beat select; illegal selects are swallowed and counted.
module demux3_stream
  import demux3_stream_pkg::*;
#(
  parameter int unsigned NB    = WORD_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [NB-1:0]    in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [NB-1:0]    out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [NB-1:0]    out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [NB-1:0]    out2_data,
  output logic             err_sel,
  output logic [CNT_W-1:0] err_cnt
);

  logic [N_CH-1:0]  load_ok;
  logic [N_CH-1:0]  ld;
  logic             accept;
  logic             bad_acc;
  logic             err_sel_q, err_sel_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Ready depends only on the addressed slot; an illegal select is always taken and dropped.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      SEL_CH0: in_ready = load_ok[0];
      SEL_CH1: in_ready = load_ok[1];
      SEL_CH2: in_ready = load_ok[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign ld[0]   = accept && (in_sel == SEL_CH0);
  assign ld[1]   = accept && (in_sel == SEL_CH1);
  assign ld[2]   = accept && (in_sel == SEL_CH2);
  assign bad_acc = accept && (in_sel == SEL_BAD);

  always_comb begin
    err_sel_d = err_sel_q || bad_acc;
    err_cnt_d = err_cnt_q;
    if (bad_acc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_sel_q <= err_sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_sel = err_sel_q;
  assign err_cnt = err_cnt_q;

  demux3_slot #(.NB(NB)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld[0]),
    .ld_data (in_data),
    .valid   (out0_valid),
    .ready   (out0_ready),
    .data    (out0_data),
    .load_ok (load_ok[0])
  );

  demux3_slot #(.NB(NB)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld[1]),
    .ld_data (in_data),
    .valid   (out1_valid),
    .ready   (out1_ready),
    .data    (out1_data),
    .load_ok (load_ok[1])
  );

  demux3_slot #(.NB(NB)) u_slot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld[2]),
    .ld_data (in_data),
    .valid   (out2_valid),
    .ready   (out2_ready),
    .data    (out2_data),
    .load_ok (load_ok[2])
  );

endmodule

// File: tb/tb_demux3_stream.sv
// Bench for demux3_stream: directed steps plus random traffic, checked against a per-channel
// scoreboard; a second instance with a 2-bit error counter exercises saturation.
module tb_demux3_stream;

  localparam int unsigned NB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, s_in_ready;
  logic [1:0]    in_sel;
  logic [NB-1:0] in_data;
  logic [2:0]    ordy;
  logic [2:0]    ov, s_ov;
  logic [NB-1:0] od [3];
  logic [NB-1:0] s_od [3];
  logic          err_sel, s_err_sel;
  logic [7:0]    err_cnt;
  logic [1:0]    s_err_cnt;

  logic [NB-1:0] sbq [3][$];
  logic [2:0]    m_valid;
  logic          m_err_sel;
  int            m_cnt;
  int            n_checks = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  demux3_stream #(.NB(NB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(ov[0]), .out0_ready(ordy[0]), .out0_data(od[0]),
    .out1_valid(ov[1]), .out1_ready(ordy[1]), .out1_data(od[1]),
    .out2_valid(ov[2]), .out2_ready(ordy[2]), .out2_data(od[2]),
    .err_sel(err_sel), .err_cnt(err_cnt)
  );

  demux3_stream #(.NB(NB), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(s_ov[0]), .out0_ready(ordy[0]), .out0_data(s_od[0]),
    .out1_valid(s_ov[1]), .out1_ready(ordy[1]), .out1_data(s_od[1]),
    .out2_valid(s_ov[2]), .out2_ready(ordy[2]), .out2_data(s_od[2]),
    .err_sel(s_err_sel), .err_cnt(s_err_cnt)
  );

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs set; checks, updates the model, advances one cycle.
  task automatic cycle();
    logic exp_rdy, acc, drn, ldn;
    int   s;
    #1;
    s = int'(in_sel);
    exp_rdy = (in_sel == 2'd3) ? 1'b1 : (!m_valid[s] || ordy[s]);
    check("in_ready", in_ready, exp_rdy);
    check("sat_in_ready", s_in_ready, exp_rdy);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("out%0d_valid", n), ov[n], m_valid[n]);
      check($sformatf("sat_out%0d_valid", n), s_ov[n], m_valid[n]);
      if (m_valid[n]) begin
        check($sformatf("out%0d_data", n), od[n], sbq[n][0]);
        check($sformatf("sat_out%0d_data", n), s_od[n], sbq[n][0]);
      end
    end
    check("err_sel", err_sel, m_err_sel);
    check("sat_err_sel", s_err_sel, m_err_sel);
    check("err_cnt", err_cnt, (m_cnt > 255) ? 255 : m_cnt);
    check("sat_err_cnt", s_err_cnt, (m_cnt > 3) ? 3 : m_cnt);
    acc = in_valid && exp_rdy;
    for (int n = 0; n < 3; n++) begin
      drn = m_valid[n] && ordy[n];
      ldn = acc && (s == n);
      if (drn) void'(sbq[n].pop_front());
      if (ldn) sbq[n].push_back(in_data);
      m_valid[n] = ldn || (m_valid[n] && !ordy[n]);
    end
    if (acc && in_sel == 2'd3) begin
      m_err_sel = 1'b1;
      m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic v, input logic [1:0] s, input logic [NB-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    cycle();
  endtask

  task automatic check_reset_state(input string tag);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("%s_out%0d_valid", tag, n), ov[n], 0);
      check($sformatf("%s_out%0d_data", tag, n), od[n], 0);
    end
    check({tag, "_err_sel"}, err_sel, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; ordy = 3'b000;
    m_valid = 3'b000; m_err_sel = 1'b0; m_cnt = 0;

    // Power-on reset
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 2'd0, '0);

    // Fill all three slots, then reset mid-stream
    ordy = 3'b000;
    beat(1'b1, 2'd0, 32'h100);
    beat(1'b1, 2'd1, 32'h101);
    beat(1'b1, 2'd2, 32'h102);
    check("full_valid", ov, 3'b111);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h103;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    m_valid = 3'b000; m_err_sel = 1'b0; m_cnt = 0;
    for (int n = 0; n < 3; n++) sbq[n].delete();
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 2'd1, 32'h11);
    check("post_rst_ch1_valid", ov[1], 1);
    check("post_rst_ch1_data", od[1], 32'h11);

    // Streaming to ch0 at full rate
    ordy = 3'b111;
    for (int i = 0; i < 8; i++) beat(1'b1, 2'd0, NB'(i));
    beat(1'b0, 2'd0, '0);

    // Backpressure isolation on ch1
    ordy = 3'b101;
    beat(1'b1, 2'd1, 32'hAA);
    repeat (3) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hBB;
      #1;
      check("bp_in_ready_low", in_ready, 0);
      check("bp_hold_data", od[1], 32'hAA);
      cycle();
    end
    beat(1'b1, 2'd2, 32'hB0);
    beat(1'b1, 2'd2, 32'hC0);
    ordy[1] = 1'b1;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hBB;
    #1;
    check("bp_release_ready", in_ready, 1);
    cycle();
    beat(1'b0, 2'd0, '0);

    // Illegal selects, then saturation of the 2-bit counter
    ordy = 3'b111;
    beat(1'b0, 2'd0, '0);
    repeat (3) beat(1'b1, 2'd3, $urandom);
    beat(1'b0, 2'd0, '0);
    check("bad_no_valid", ov, 3'b000);
    check("bad_err_sel", err_sel, 1);
    check("bad_err_cnt3", err_cnt, 3);
    repeat (2) beat(1'b1, 2'd3, $urandom);
    beat(1'b0, 2'd0, '0);
    check("bad_err_cnt5", err_cnt, 5);
    check("sat_err_cnt_cap", s_err_cnt, 3);

    // Drain and load on the same cycle
    ordy = 3'b000;
    beat(1'b1, 2'd2, 32'h1);
    ordy[2] = 1'b1;
    beat(1'b1, 2'd2, 32'h2);
    check("dl_valid", ov[2], 1);
    check("dl_data", od[2], 32'h2);
    ordy = 3'b111;
    beat(1'b0, 2'd0, '0);

    // Random traffic
    repeat (10000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = $urandom;
      for (int n = 0; n < 3; n++) ordy[n] = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid = 1'b0;
    ordy = 3'b111;
    repeat (3) cycle();
    for (int n = 0; n < 3; n++) check($sformatf("sb_empty%0d", n), NB'(sbq[n].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
